// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// coin codes and the product price function.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam int unsigned COIN_W = 3;

  localparam logic [COIN_W-1:0] COIN_NONE = 3'd0;
  localparam logic [COIN_W-1:0] COIN_5    = 3'd1;
  localparam logic [COIN_W-1:0] COIN_10   = 3'd2;
  localparam logic [COIN_W-1:0] COIN_25   = 3'd3;
  localparam logic [COIN_W-1:0] COIN_100  = 3'd4;

  localparam int unsigned PRICE_STEP = 25;

  // Price in cents of product idx: 25, 50, 75, ...
  function automatic int unsigned price(input int unsigned idx);
    return PRICE_STEP * (idx + 1);
  endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder.
// Ports: coin (code in), value_c (cents out), invalid_c (code 5-7 out).
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [COIN_W-1:0] coin,
  output logic [W-1:0]      value_c,
  output logic              invalid_c
);

  always_comb begin
    value_c   = '0;
    invalid_c = 1'b0;
    case (coin)
      COIN_NONE: value_c = '0;
      COIN_5:    value_c = W'(5);
      COIN_10:   value_c = W'(10);
      COIN_25:   value_c = W'(25);
      COIN_100:  value_c = W'(100);
      default:   invalid_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/vending_controller.sv
// Vending machine controller: accumulates coin credit, sells products,
// returns change or refunds on cancel.
// Ports: clk, reset_n (async active-low); coin_valid/coin, sel_valid/sel,
// cancel, restock in; credit, busy, dispense/dispense_id,
// change_valid/change, coin_reject, short_credit, sold_out out (registered).
// Optional macro VEND_STOCK_EN: per-product stock counters, sold_out and
// restock; without it sold_out stays 0 and restock is ignored.
module vending_controller
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned CREDIT_W     = 8,
  parameter int unsigned MAX_CREDIT   = 200,
  parameter int unsigned STOCK_W      = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            coin_valid,
  input  logic [2:0]                      coin,
  input  logic                            sel_valid,
  input  logic [$clog2(NUM_PRODUCTS)-1:0] sel,
  input  logic                            cancel,
  input  logic                            restock,
  output logic [CREDIT_W-1:0]             credit,
  output logic                            busy,
  output logic                            dispense,
  output logic [$clog2(NUM_PRODUCTS)-1:0] dispense_id,
  output logic                            change_valid,
  output logic [CREDIT_W-1:0]             change,
  output logic                            coin_reject,
  output logic                            short_credit,
  output logic                            sold_out
);

  localparam int unsigned SEL_W = $clog2(NUM_PRODUCTS);
  localparam int unsigned SUM_W = CREDIT_W + 1;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CREDIT_W-1:0] credit_d, change_d, coin_value;
  logic [SEL_W-1:0]    dispense_id_d;
  logic                busy_d, dispense_d, change_valid_d;
  logic                coin_reject_d, short_credit_d, sold_out_d;
  logic                coin_invalid, coin_present, sel_ok;
  logic [SUM_W-1:0]    coin_sum;

  vend_coin_decode #(.W(CREDIT_W)) u_coin_decode (
    .coin      (coin),
    .value_c   (coin_value),
    .invalid_c (coin_invalid)
  );

  // Code 0 is "no coin" even when coin_valid is high.
  assign coin_present = coin_valid && (coin != COIN_NONE);
  assign sel_ok       = 32'(sel) < NUM_PRODUCTS;
  assign coin_sum     = {1'b0, credit} + {1'b0, coin_value};

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock [NUM_PRODUCTS];
  logic               stock_dec, stock_load, stock_empty;

  assign stock_empty = (stock[sel] == '0);

  // Stock counters: full at reset, reload on restock, count down per sale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_PRODUCTS); i++) stock[i] <= '1;
    end else if (stock_load) begin
      stock[sel] <= '1;
    end else if (stock_dec) begin
      stock[sel] <= stock[sel] - STOCK_W'(1);
    end
  end
`else
  logic [32:0] unused_cfg;
  assign unused_cfg = {restock, 32'(STOCK_W)};
`endif

  // Next-state and next-output logic; priority cancel > restock > sel > coin.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    credit_d       = credit;
    dispense_d     = 1'b0;
    dispense_id_d  = '0;
    change_valid_d = 1'b0;
    change_d       = '0;
    coin_reject_d  = 1'b0;
    short_credit_d = 1'b0;
    sold_out_d     = 1'b0;
`ifdef VEND_STOCK_EN
    stock_dec      = 1'b0;
    stock_load     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cancel && (credit != '0)) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_d       = credit;
          credit_d       = '0;
          coin_reject_d  = coin_present;
        end
`ifdef VEND_STOCK_EN
        else if (restock && sel_ok) begin
          stock_load    = 1'b1;
          coin_reject_d = coin_present;
        end
`endif
        else if (sel_valid && sel_ok) begin
          // A selection consumes the cycle, so a same-cycle coin bounces.
          coin_reject_d = coin_present;
`ifdef VEND_STOCK_EN
          if (stock_empty) sold_out_d = 1'b1;
          else
`endif
          if (32'(credit) < price(32'(sel))) begin
            short_credit_d = 1'b1;
          end else begin
            state_d       = VEND;
            sel_d         = sel;
            dispense_d    = 1'b1;
            dispense_id_d = sel;
`ifdef VEND_STOCK_EN
            stock_dec     = 1'b1;
`endif
          end
        end else if (coin_present) begin
          if (coin_invalid || (coin_sum > SUM_W'(MAX_CREDIT))) coin_reject_d = 1'b1;
          else credit_d = coin_sum[CREDIT_W-1:0];
        end
      end
      VEND: begin
        state_d        = CHANGE;
        change_valid_d = 1'b1;
        change_d       = credit - CREDIT_W'(price(32'(sel_q)));
        credit_d       = '0;
        coin_reject_d  = coin_present;
      end
      CHANGE: begin
        state_d       = IDLE;
        coin_reject_d = coin_present;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      credit       <= '0;
      busy         <= 1'b0;
      dispense     <= 1'b0;
      dispense_id  <= '0;
      change_valid <= 1'b0;
      change       <= '0;
      coin_reject  <= 1'b0;
      short_credit <= 1'b0;
      sold_out     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      credit       <= credit_d;
      busy         <= busy_d;
      dispense     <= dispense_d;
      dispense_id  <= dispense_id_d;
      change_valid <= change_valid_d;
      change       <= change_d;
      coin_reject  <= coin_reject_d;
      short_credit <= short_credit_d;
      sold_out     <= sold_out_d;
    end
  end

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller: a table of per-cycle vectors
// with expected registered outputs, checked through a scoreboard queue,
// plus a hand-written reset-during-VEND sequence.
module tb_vending_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       coin_valid, sel_valid, cancel, restock;
  logic [2:0] coin;
  logic [1:0] sel;
  logic [7:0] credit, change;
  logic       busy, dispense, change_valid, coin_reject, short_credit, sold_out;
  logic [1:0] dispense_id;

  typedef struct packed {
    logic       cv;
    logic [2:0] coin;
    logic       sv;
    logic [1:0] sel;
    logic       cancel;
    logic       restock;
  } ins_t;

  typedef struct packed {
    logic [7:0] credit;
    logic       busy;
    logic       disp;
    logic [1:0] id;
    logic       chv;
    logic [7:0] chg;
    logic       rej;
    logic       shrt;
    logic       sold;
  } outs_t;

  typedef struct {
    string name;
    ins_t  in;
    outs_t exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  vending_controller #(
    .NUM_PRODUCTS(4), .CREDIT_W(8), .MAX_CREDIT(200), .STOCK_W(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel(sel),
    .cancel(cancel), .restock(restock),
    .credit(credit), .busy(busy),
    .dispense(dispense), .dispense_id(dispense_id),
    .change_valid(change_valid), .change(change),
    .coin_reject(coin_reject), .short_credit(short_credit),
    .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  function automatic void add(input string n, input logic cv, input logic [2:0] c,
                              input logic sv, input logic [1:0] s, input logic can,
                              input logic rs, input logic [7:0] cr, input logic b,
                              input logic d, input logic [1:0] id, input logic chv,
                              input logic [7:0] chg, input logic rj, input logic sh,
                              input logic so);
    vec_t v;
    v.name = n;
    v.in   = '{cv: cv, coin: c, sv: sv, sel: s, cancel: can, restock: rs};
    v.exp  = '{credit: cr, busy: b, disp: d, id: id, chv: chv, chg: chg,
               rej: rj, shrt: sh, sold: so};
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = '{credit: credit, busy: busy, disp: dispense, id: dispense_id,
            chv: change_valid, chg: change, rej: coin_reject,
            shrt: short_credit, sold: sold_out};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got credit=%0d busy=%b disp=%b id=%0d chv=%b chg=%0d rej=%b short=%b sold=%b, want credit=%0d busy=%b disp=%b id=%0d chv=%b chg=%0d rej=%b short=%b sold=%b",
               name, act.credit, act.busy, act.disp, act.id, act.chv, act.chg,
               act.rej, act.shrt, act.sold, exp.credit, exp.busy, exp.disp,
               exp.id, exp.chv, exp.chg, exp.rej, exp.shrt, exp.sold);
    end
  endtask

  task automatic drive(input ins_t in);
    coin_valid = in.cv;
    coin       = in.coin;
    sel_valid  = in.sv;
    sel        = in.sel;
    cancel     = in.cancel;
    restock    = in.restock;
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v.in);
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue, want one entry");
    end else begin
      e = sb.pop_front();
      check(e.name, e.exp);
    end
  endtask

  initial begin
    vec_t  v;
    outs_t zero;
    zero = '0;
    reset_n = 1'b1;
    drive('0);
    #2 reset_n = 1'b0;
    #1 check("reset state", zero);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Reset during VEND with credit 100: the pending refund is discarded.
    v.name = "rst c100";
    v.in   = '{cv: 1'b1, coin: 3'd4, default: '0};
    v.exp  = '{credit: 8'd100, default: '0};
    apply(v);
    v.name = "rst sel1";
    v.in   = '{sv: 1'b1, sel: 2'd1, default: '0};
    v.exp  = '{credit: 8'd100, busy: 1'b1, disp: 1'b1, id: 2'd1, default: '0};
    apply(v);
    @(negedge clk);
    drive('0);
    reset_n = 1'b0;
    #1 check("reset mid VEND", zero);
    @(posedge clk);
    #1 check("reset held", zero);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 check("after reset no change", zero);
    @(posedge clk);
    #1 check("after reset idle", zero);

`ifdef VEND_STOCK_EN
    add("stk c25",      1, 3'd3, 0, 0, 0, 0,  25, 0, 0, 0, 0,  0, 0, 0, 0);
    add("stk buy0",     0, 0,    1, 0, 0, 0,  25, 1, 1, 0, 0,  0, 0, 0, 0);
    add("stk chg0",     0, 0,    0, 0, 0, 0,   0, 1, 0, 0, 1,  0, 0, 0, 0);
    add("stk idle",     0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("stk c25b",     1, 3'd3, 0, 0, 0, 0,  25, 0, 0, 0, 0,  0, 0, 0, 0);
    add("stk soldout",  0, 0,    1, 0, 0, 0,  25, 0, 0, 0, 0,  0, 0, 0, 1);
    add("stk restock",  0, 0,    0, 0, 0, 1,  25, 0, 0, 0, 0,  0, 0, 0, 0);
    add("stk rebuy",    0, 0,    1, 0, 0, 0,  25, 1, 1, 0, 0,  0, 0, 0, 0);
    add("stk rechg",    0, 0,    0, 0, 0, 0,   0, 1, 0, 0, 1,  0, 0, 0, 0);
    add("stk idle2",    0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0);
`endif
    add("s1 c25",       1, 3'd3, 0, 0, 0, 0,  25, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s1 c25b",      1, 3'd3, 0, 0, 0, 0,  50, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s1 c100",      1, 3'd4, 0, 0, 0, 0, 150, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s1 sel1",      0, 0,    1, 1, 0, 0, 150, 1, 1, 1, 0,  0, 0, 0, 0);
    add("s1 change",    0, 0,    0, 0, 0, 0,   0, 1, 0, 0, 1,100, 0, 0, 0);
    add("s1 idle",      0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s2 c100",      1, 3'd4, 0, 0, 0, 0, 100, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s2 c100 max",  1, 3'd4, 0, 0, 0, 0, 200, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s2 c5 over",   1, 3'd1, 0, 0, 0, 0, 200, 0, 0, 0, 0,  0, 1, 0, 0);
    add("s2 code5",     1, 3'd5, 0, 0, 0, 0, 200, 0, 0, 0, 0,  0, 1, 0, 0);
    add("s2 cancel",    0, 0,    0, 0, 1, 0,   0, 1, 0, 0, 1,200, 0, 0, 0);
    add("s2 coin busy", 1, 3'd2, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 1, 0, 0);
    add("s3 c25",       1, 3'd3, 0, 0, 0, 0,  25, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s3 c5",        1, 3'd1, 0, 0, 0, 0,  30, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s3 short",     0, 0,    1, 2, 0, 0,  30, 0, 0, 0, 0,  0, 0, 1, 0);
    add("s3 cancel",    0, 0,    0, 0, 1, 0,   0, 1, 0, 0, 1, 30, 0, 0, 0);
    add("s3 idle",      0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s4 c25",       1, 3'd3, 0, 0, 0, 0,  25, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s4 c25b",      1, 3'd3, 0, 0, 0, 0,  50, 0, 0, 0, 0,  0, 0, 0, 0);
    add("s4 prio",      1, 3'd2, 1, 1, 1, 0,   0, 1, 0, 0, 1, 50, 1, 0, 0);
    add("s4 idle",      0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("z cancel0",    0, 0,    0, 0, 1, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("z short0",     0, 0,    1, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 1, 0);
    add("z restock",    0, 0,    0, 0, 0, 1,   0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("z c25",        1, 3'd3, 0, 0, 0, 0,  25, 0, 0, 0, 0,  0, 0, 0, 0);
    add("z buy0",       0, 0,    1, 0, 0, 0,  25, 1, 1, 0, 0,  0, 0, 0, 0);
    add("z change0",    0, 0,    0, 0, 0, 0,   0, 1, 0, 0, 1,  0, 0, 0, 0);
    add("z idle",       0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0);
    add("b c100",       1, 3'd4, 0, 0, 0, 0, 100, 0, 0, 0, 0,  0, 0, 0, 0);
    add("b buy3",       0, 0,    1, 3, 0, 0, 100, 1, 1, 3, 0,  0, 0, 0, 0);
    add("b vend ign",   1, 3'd3, 1, 0, 1, 0,   0, 1, 0, 0, 1,  0, 1, 0, 0);
    add("b idle",       0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    @(negedge clk);
    drive('0);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard drain: got %0d left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
